// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl: load-use hazard detector and multi-cycle stall sequencer between ID and EX.
// Optional HAZARD_STATS_EN adds saturating stall_total / hazard_events counters.
`default_nettype none

module load_hazard_ctrl #(
    parameter int REG_AW     = 4,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              flush,
    output logic              repeated,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_total,
    output logic [15:0]       hazard_events
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_AW-1:0]   hold_rd_q, hold_rd_d;
    logic                hazard;
    logic                stall_now;
    logic                dbg_unused_hold;

    assign hazard = id_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // Flush kills the ID instruction, so it needs no hold; reset masks the request too.
    assign stall_now   = !reset && !flush && ((state_q == STALL) || hazard);
    assign repeated    = stall_now;
    assign idex_bubble = stall_now;
    assign stall_cnt   = cnt_q;
    assign busy        = (state_q == STALL);

    // hold_rd is a debug observation point only.
    assign dbg_unused_hold = ^hold_rd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_rd_d = hold_rd_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (hazard && (LOAD_STALL > 1)) begin
                        state_d   = STALL;
                        cnt_d     = CNT_W'(1);
                        hold_rd_d = ex_rd;
                    end
                end
                STALL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_rd_q <= hold_rd_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_total_q;
    logic [15:0] hazard_events_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_total_q   <= '0;
            hazard_events_q <= '0;
        end else begin
            if (stall_now && (stall_total_q != 16'hFFFF))
                stall_total_q <= stall_total_q + 16'd1;
            if ((state_q == IDLE) && hazard && !flush && (hazard_events_q != 16'hFFFF))
                hazard_events_q <= hazard_events_q + 16'd1;
        end
    end

    assign stall_total   = stall_total_q;
    assign hazard_events = hazard_events_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_hazard_ctrl.sv
// tb_load_hazard_ctrl: directed checks of load_hazard_ctrl at LOAD_STALL = 1, 2, 3 and 4.
`default_nettype none

module tb_load_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, ex_mem_read, flush;
    logic [3:0] id_rs1, id_rs2, ex_rd;

    logic       rep1, bub1, busy1;
    logic [2:0] cnt1;
    logic       rep2, bub2, busy2;
    logic [2:0] cnt2;
    logic       rep3, bub3, busy3;
    logic [2:0] cnt3;
    logic       rep4, bub4, busy4;
    logic [2:0] cnt4;
`ifdef HAZARD_STATS_EN
    logic [15:0] tot2, evt2;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(1), .CNT_W(3)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .repeated(rep1), .idex_bubble(bub1),
        .stall_cnt(cnt1), .busy(busy1)
`ifdef HAZARD_STATS_EN
        , .stall_total(), .hazard_events()
`endif
    );

    load_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(2), .CNT_W(3)) u2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .repeated(rep2), .idex_bubble(bub2),
        .stall_cnt(cnt2), .busy(busy2)
`ifdef HAZARD_STATS_EN
        , .stall_total(tot2), .hazard_events(evt2)
`endif
    );

    load_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(3), .CNT_W(3)) u3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .repeated(rep3), .idex_bubble(bub3),
        .stall_cnt(cnt3), .busy(busy3)
`ifdef HAZARD_STATS_EN
        , .stall_total(), .hazard_events()
`endif
    );

    load_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(4), .CNT_W(3)) u4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .repeated(rep4), .idex_bubble(bub4),
        .stall_cnt(cnt4), .busy(busy4)
`ifdef HAZARD_STATS_EN
        , .stall_total(), .hazard_events()
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; flush = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic hazard_rs1(input logic [3:0] r);
        id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 0; id_rs1 = r; id_rs2 = 0;
        ex_mem_read = 1; ex_rd = r;
    endtask

    task automatic hazard_rs2(input logic [3:0] r);
        id_valid = 1; id_use_rs1 = 0; id_use_rs2 = 1; id_rs1 = 0; id_rs2 = r;
        ex_mem_read = 1; ex_rd = r;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        cycle();
        cycle();
        #1;
        chk("rep_during_reset", 16'(rep3), 16'd0);
        chk("bub_during_reset", 16'(bub3), 16'd0);
        reset = 0;
        #1;
        chk("reset_busy", 16'(busy3), 16'd0);
        chk("reset_cnt", 16'(cnt3), 16'd0);
        chk("reset_rep", 16'(rep4), 16'd0);

        // LOAD_STALL=1: one-cycle stall, then EX holds a bubble
        do_reset();
        hazard_rs1(4'd5);
        #1;
        chk("ls1_rep", 16'(rep1), 16'd1);
        chk("ls1_bub", 16'(bub1), 16'd1);
        chk("ls1_cnt", 16'(cnt1), 16'd0);
        chk("ls1_busy", 16'(busy1), 16'd0);
        cycle();
        ex_mem_read = 0;
        #1;
        chk("ls1_rep_after", 16'(rep1), 16'd0);
        chk("ls1_cnt_after", 16'(cnt1), 16'd0);
        chk("ls1_busy_after", 16'(busy1), 16'd0);

        // LOAD_STALL=3 on rs2
        do_reset();
        hazard_rs2(4'd7);
        #1;
        chk("ls3_c1_rep", 16'(rep3), 16'd1);
        chk("ls3_c1_cnt", 16'(cnt3), 16'd0);
        chk("ls3_c1_busy", 16'(busy3), 16'd0);
        cycle();
        ex_mem_read = 0;
        #1;
        chk("ls3_c2_rep", 16'(rep3), 16'd1);
        chk("ls3_c2_cnt", 16'(cnt3), 16'd1);
        chk("ls3_c2_busy", 16'(busy3), 16'd1);
        cycle();
        #1;
        chk("ls3_c3_rep", 16'(rep3), 16'd1);
        chk("ls3_c3_bub", 16'(bub3), 16'd1);
        chk("ls3_c3_cnt", 16'(cnt3), 16'd2);
        chk("ls3_c3_busy", 16'(busy3), 16'd1);
        cycle();
        #1;
        chk("ls3_end_rep", 16'(rep3), 16'd0);
        chk("ls3_end_cnt", 16'(cnt3), 16'd0);
        chk("ls3_end_busy", 16'(busy3), 16'd0);

        // Non-hazards
        do_reset();
        hazard_rs1(4'd0);
        #1;
        chk("rd0_rep_ls1", 16'(rep1), 16'd0);
        chk("rd0_rep_ls3", 16'(rep3), 16'd0);
        hazard_rs1(4'd5);
        id_use_rs1 = 0;
        #1;
        chk("nouse_rep", 16'(rep3), 16'd0);
        hazard_rs1(4'd5);
        ex_mem_read = 0;
        #1;
        chk("noload_rep", 16'(rep3), 16'd0);
        hazard_rs1(4'd5);
        id_valid = 0;
        #1;
        chk("novalid_rep", 16'(rep1), 16'd0);
        hazard_rs1(4'd5);
        ex_rd = 4'd6;
        #1;
        chk("nomatch_rep", 16'(rep4), 16'd0);
        cycle();
        #1;
        chk("nonhaz_busy", 16'(busy3), 16'd0);

        // LOAD_STALL=4, flush in 2nd stall cycle
        do_reset();
        hazard_rs1(4'd3);
        #1;
        chk("fl_c1_rep", 16'(rep4), 16'd1);
        cycle();
        ex_mem_read = 0;
        flush = 1;
        #1;
        chk("fl_c2_rep", 16'(rep4), 16'd0);
        chk("fl_c2_bub", 16'(bub4), 16'd0);
        chk("fl_c2_cnt", 16'(cnt4), 16'd1);
        cycle();
        flush = 0;
        id_valid = 0;
        #1;
        chk("fl_c3_cnt", 16'(cnt4), 16'd0);
        chk("fl_c3_busy", 16'(busy4), 16'd0);
        chk("fl_c3_rep", 16'(rep4), 16'd0);

        // LOAD_STALL=3, reset in 2nd stall cycle
        do_reset();
        hazard_rs1(4'd9);
        cycle();
        ex_mem_read = 0;
        reset = 1;
        #1;
        chk("rs_c2_rep", 16'(rep3), 16'd0);
        chk("rs_c2_busy", 16'(busy3), 16'd1);
        cycle();
        reset = 0;
        #1;
        chk("rs_c3_cnt", 16'(cnt3), 16'd0);
        chk("rs_c3_busy", 16'(busy3), 16'd0);
        chk("rs_c3_rep", 16'(rep3), 16'd0);

        // LOAD_STALL=3, new load-use arrives on the return edge
        do_reset();
        hazard_rs2(4'd7);
        cycle();
        ex_mem_read = 0;
        cycle();
        ex_mem_read = 1;
        #1;
        chk("b2b_last_cnt", 16'(cnt3), 16'd2);
        cycle();
        #1;
        chk("b2b_idle_rep", 16'(rep3), 16'd1);
        chk("b2b_idle_cnt", 16'(cnt3), 16'd0);
        chk("b2b_idle_busy", 16'(busy3), 16'd0);
        cycle();
        ex_mem_read = 0;
        #1;
        chk("b2b_stall_cnt", 16'(cnt3), 16'd1);
        chk("b2b_stall_busy", 16'(busy3), 16'd1);

        // LOAD_STALL=2: two separate hazards
        do_reset();
        hazard_rs1(4'd4);
        #1;
        chk("ls2_h1_rep", 16'(rep2), 16'd1);
        cycle();
        ex_mem_read = 0;
        #1;
        chk("ls2_h1_c2_cnt", 16'(cnt2), 16'd1);
        chk("ls2_h1_c2_rep", 16'(rep2), 16'd1);
        cycle();
        #1;
        chk("ls2_h1_done", 16'(rep2), 16'd0);
        cycle();
        hazard_rs2(4'd11);
        cycle();
        ex_mem_read = 0;
        cycle();
        #1;
        chk("ls2_h2_done_busy", 16'(busy2), 16'd0);
`ifdef HAZARD_STATS_EN
        chk("stats_events", evt2, 16'd2);
        chk("stats_total", tot2, 16'd4);
        do_reset();
        #1;
        chk("stats_events_rst", evt2, 16'd0);
        chk("stats_total_rst", tot2, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_hazard_ctrl.md
Name: load_hazard_ctrl

Overview:
- Load-use hazard controller for the 16-bit pipelined CPU.
- Sits between the ID and EX stages. Compares the registers read by the instruction in ID against the destination of a load in EX.
- Generates the stall signal that holds the program counter and IF/ID register, plus the bubble insert into ID/EX.
- Sequences multi-cycle load stalls and reports the running stall count to the PC stage.

Parameters:
- REG_AW, 4, register-index width (16 architectural registers; register 0 is hardwired zero).
- LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..7.
- CNT_W, 3, stall-counter width; must hold LOAD_STALL.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  ID source register 1.
- id_rs2  input  REG_AW  ID source register 2.
- id_use_rs1  input  1  ID instruction actually reads rs1.
- id_use_rs2  input  1  ID instruction actually reads rs2.
- ex_mem_read  input  1  EX instruction is a load.
- ex_rd  input  REG_AW  EX destination register.
- flush  input  1  taken branch/jump; kills ID contents.
- repeated  output  1  PC/IF-ID hold request (PC keeps its address).
- idex_bubble  output  1  force ID/EX to NOP this cycle.
- stall_cnt  output  CNT_W  stall cycles completed in the current episode.
- busy  output  1  FSM is in STALL state.

Behaviour:
- Hazard term (combinational):
  - hazard = id_valid & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- States: IDLE, STALL. Internal registers: state, stall_cnt, hold_rd (REG_AW).
- IDLE:
  - repeated = idex_bubble = hazard & ~flush.
  - On hazard & ~flush & LOAD_STALL == 1: stall_cnt <= 0, stay IDLE. This is a single-cycle stall; the bubble removes the hazard next cycle.
  - On hazard & ~flush & LOAD_STALL > 1: go to STALL, stall_cnt <= 1, hold_rd <= ex_rd.
- STALL:
  - repeated = idex_bubble = 1; busy = 1.
  - Each cycle stall_cnt <= stall_cnt + 1.
  - When stall_cnt == LOAD_STALL-1: go to IDLE, stall_cnt <= 0. Total stall = LOAD_STALL cycles.
  - EX inputs are ignored in STALL (EX holds a bubble). hold_rd records the load destination for debug and the optional feature.
- stall_cnt:
  - 0 whenever not stalling.
  - Never exceeds LOAD_STALL-1.
  - Saturates at 2^CNT_W-1 as a guard and never wraps.
- flush:
  - In any state, flush has priority: next state IDLE, stall_cnt <= 0.
  - repeated = idex_bubble = 0 in the flush cycle. The killed instruction needs no operands.
- A new hazard arriving on the same edge the FSM returns to IDLE is evaluated combinationally in IDLE the following cycle. No hazard is lost and no extra bubble is inserted.
- Reset: state = IDLE, stall_cnt = 0, hold_rd = 0, busy = 0. repeated = 0 and idex_bubble = 0 during and after reset until a hazard occurs. Reset mid-stall aborts the stall immediately on the next edge.
- Loads to register 0 never stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds output stall_total [15:0], incremented on every cycle with repeated == 1. Saturates at 16'hFFFF.
  - Adds output hazard_events [15:0], incremented once per hazard detected in IDLE. Also saturating.
  - Both counters clear on reset.
- When undefined: neither port nor counter exists, and stall behaviour is identical.

Test Plan:
- LOAD_STALL=1, ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, id_valid=1 -> repeated=1 and idex_bubble=1 for exactly 1 cycle, stall_cnt stays 0, busy=0.
- LOAD_STALL=3, same hazard on rs2=7/ex_rd=7 -> repeated high 3 consecutive cycles, stall_cnt reads 0,1,2 across them, busy=1 on cycles 2–3, then all outputs 0.
- ex_rd=0 with id_rs1=0, or id_use_rs1=0 with a matching index, or ex_mem_read=0 -> repeated stays 0.
- LOAD_STALL=4, assert flush during the 2nd stall cycle -> repeated=0 that cycle, state IDLE, stall_cnt=0 next cycle.
- LOAD_STALL=3, assert reset during the 2nd stall cycle -> next edge: stall_cnt=0, busy=0, repeated=0 with no hazard present.
- HAZARD_STATS_EN, LOAD_STALL=2, two separate hazards -> hazard_events=2, stall_total=4; reset clears both to 0.
